// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// configuration register map and STAT register layout.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_PEND  = 2'd1;
    localparam logic [1:0] ADDR_VBASE = 2'd2;
    localparam logic [1:0] ADDR_STAT  = 2'd3;

    localparam int unsigned ID_W          = 3;
    localparam int unsigned STAT_BUSY_BIT = 7;
    localparam int unsigned STAT_ID_LSB   = 0;

    function automatic logic [31:0] stat_word(input logic busy, input logic [ID_W-1:0] id);
        logic [31:0] w;
        w                         = '0;
        w[STAT_BUSY_BIT]          = busy;
        w[STAT_ID_LSB +: ID_W]    = id;
        return w;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request bit (bit 0 wins).
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    logic [N-1:0] shifted;

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        shifted = '0;
        for (int unsigned i = 0; i < N; i++) begin
            shifted = req_i >> i;
            if (shifted[0] && !valid_o) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctl.sv
// Edge-triggered interrupt controller with mask/pending/vector-base registers.
// Define IRQ_CTL_SYNC_EN to add a 2-flop synchronizer on every source line.
module irq_ctl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC           = 8,
    parameter logic [31:0] VEC_BASE_RST    = 32'h0000_0050,
    parameter int unsigned VEC_STRIDE_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic             iack_i,
    output logic             irq_o,
    output logic [31:0]      irq_addr_o,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [31:0]      cfg_din_i,
    output logic [31:0]      cfg_dout_o
);

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] hist_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] mask_q,  mask_d;
    logic [N_SRC-1:0] pend_q,  pend_d;
    logic [N_SRC-1:0] w1c_clr, ack_clr;
    logic [31:2]      vbase_q, vbase_d;
    irq_state_e       state_q;
    logic [ID_W-1:0]  cur_id_q;
    logic             irq_q;
    logic [31:0]      addr_q;
    logic             enc_valid;
    logic [ID_W-1:0]  enc_id;
    logic             wr_mask, wr_pend, wr_vbase, eoi, ack_fire, busy;
    logic             unused_din;

`ifdef IRQ_CTL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src_i;
`endif

    assign rise       = src_s & ~hist_q;
    assign unused_din = ^cfg_din_i[1:0];

    assign wr_mask  = cfg_we_i && (cfg_addr_i == ADDR_MASK);
    assign wr_pend  = cfg_we_i && (cfg_addr_i == ADDR_PEND);
    assign wr_vbase = cfg_we_i && (cfg_addr_i == ADDR_VBASE);
    assign eoi      = cfg_we_i && (cfg_addr_i == ADDR_STAT);
    assign ack_fire = (state_q == ST_REQ) && iack_i;
    assign busy     = (state_q != ST_IDLE);

    // Clears are applied before new edges are OR-ed in, so a coincident edge keeps PEND set.
    assign w1c_clr = wr_pend  ? cfg_din_i[N_SRC-1:0] : '0;
    assign ack_clr = ack_fire ? (N_SRC'(1'b1) << cur_id_q) : '0;
    assign pend_d  = (pend_q & ~(w1c_clr | ack_clr)) | rise;
    assign mask_d  = wr_mask  ? cfg_din_i[N_SRC-1:0] : mask_q;
    assign vbase_d = wr_vbase ? cfg_din_i[31:2]      : vbase_q;

    irq_prio_enc #(
        .N (N_SRC)
    ) u_prio (
        .req_i   (pend_q & mask_q),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            hist_q  <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            vbase_q <= VEC_BASE_RST[31:2];
        end else begin
            hist_q  <= src_s;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            vbase_q <= vbase_d;
        end
    end

    // Handler address is captured at the latch so VBASE/MASK edits cannot disturb a pending request.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cur_id_q <= '0;
            irq_q    <= 1'b0;
            addr_q   <= {VEC_BASE_RST[31:2], 2'b00};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state_q  <= ST_REQ;
                        cur_id_q <= enc_id;
                        irq_q    <= 1'b1;
                        addr_q   <= {vbase_q, 2'b00} + (32'(enc_id) << VEC_STRIDE_LOG2);
                    end
                end
                ST_REQ: begin
                    if (iack_i) begin
                        state_q <= ST_SERV;
                        irq_q   <= 1'b0;
                    end
                end
                ST_SERV: begin
                    if (eoi) begin
                        state_q  <= ST_IDLE;
                        cur_id_q <= '0;
                        addr_q   <= {vbase_q, 2'b00};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o      = irq_q;
    assign irq_addr_o = addr_q;

    always_comb begin
        cfg_dout_o = '0;
        case (cfg_addr_i)
            ADDR_MASK:  cfg_dout_o = 32'(mask_q);
            ADDR_PEND:  cfg_dout_o = 32'(pend_q);
            ADDR_VBASE: cfg_dout_o = {vbase_q, 2'b00};
            ADDR_STAT:  cfg_dout_o = stat_word(busy, cur_id_q);
            default:    cfg_dout_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: expectations are queued as stimulus is driven
// and popped in order as DUT outputs are sampled one time unit after edges.
module tb_irq_ctl;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  irq_src_i;
    logic        iack_i;
    logic        irq_o;
    logic [31:0] irq_addr_o;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_din_i;
    logic [31:0] cfg_dout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    always #10 clk = ~clk;

    irq_ctl #(
        .N_SRC           (8),
        .VEC_BASE_RST    (32'h0000_0050),
        .VEC_STRIDE_LOG2 (3)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .irq_src_i  (irq_src_i),
        .iack_i     (iack_i),
        .irq_o      (irq_o),
        .irq_addr_o (irq_addr_o),
        .cfg_we_i   (cfg_we_i),
        .cfg_addr_i (cfg_addr_i),
        .cfg_din_i  (cfg_din_i),
        .cfg_dout_o (cfg_dout_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_reg(input logic [1:0] a);
        cfg_addr_i = a;
        #1;
        check(cfg_dout_o);
    endtask

    task automatic chk_irq();
        check(32'(irq_o));
    endtask

    task automatic chk_addr();
        check(irq_addr_o);
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i   = 1'b1;
        cfg_addr_i = a;
        cfg_din_i  = d;
        tick();
        cfg_we_i   = 1'b0;
        cfg_din_i  = '0;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_src_i = irq_src_i | m;
        tick();
        irq_src_i = irq_src_i & ~m;
    endtask

    task automatic serve();
        iack_i = 1'b1;
        tick();
        iack_i = 1'b0;
        cfg_wr(ADDR_STAT, 32'h0);
    endtask

    initial begin
        rst_i      = 1'b1;
        irq_src_i  = '0;
        iack_i     = 1'b0;
        cfg_we_i   = 1'b0;
        cfg_addr_i = '0;
        cfg_din_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        push_exp("rst_irq", 32'h0);
        push_exp("rst_addr", 32'h50);
        push_exp("rst_mask", 32'h0);
        push_exp("rst_pend", 32'h0);
        push_exp("rst_vbase", 32'h50);
        push_exp("rst_stat", 32'h0);
        chk_irq(); chk_addr();
        chk_reg(ADDR_MASK); chk_reg(ADDR_PEND); chk_reg(ADDR_VBASE); chk_reg(ADDR_STAT);

        // Single source 3
        cfg_wr(ADDR_MASK, 32'hFF);
        push_exp("s3_pend", 32'h08);
        push_exp("s3_irq_early", 32'h0);
        pulse(8'h08);
        chk_reg(ADDR_PEND); chk_irq();
        push_exp("s3_irq", 32'h1);
        push_exp("s3_addr", 32'h68);
        push_exp("s3_stat_req", 32'h83);
        tick();
        chk_irq(); chk_addr(); chk_reg(ADDR_STAT);
        push_exp("s3_pend_ack", 32'h0);
        push_exp("s3_stat_serv", 32'h83);
        push_exp("s3_irq_serv", 32'h0);
        iack_i = 1'b1;
        tick();
        iack_i = 1'b0;
        chk_reg(ADDR_PEND); chk_reg(ADDR_STAT); chk_irq();
        push_exp("s3_stat_eoi", 32'h0);
        cfg_wr(ADDR_STAT, 32'h0);
        chk_reg(ADDR_STAT);

        // Acknowledge and EOI outside their states are ignored
        push_exp("idle_iack_stat", 32'h0);
        push_exp("idle_iack_irq", 32'h0);
        iack_i = 1'b1;
        tick();
        iack_i = 1'b0;
        cfg_wr(ADDR_STAT, 32'h0);
        chk_reg(ADDR_STAT); chk_irq();

        // Sources 5 and 2 together: 2 first
        pulse(8'h24);
        push_exp("p2_stat", 32'h82);
        push_exp("p2_addr", 32'h60);
        push_exp("p2_irq", 32'h1);
        tick();
        chk_reg(ADDR_STAT); chk_addr(); chk_irq();
        push_exp("p2_pend_left", 32'h20);
        iack_i = 1'b1;
        tick();
        iack_i = 1'b0;
        chk_reg(ADDR_PEND);
        cfg_wr(ADDR_STAT, 32'h0);
        push_exp("p5_stat", 32'h85);
        push_exp("p5_addr", 32'h78);
        push_exp("p5_irq", 32'h1);
        tick();
        chk_reg(ADDR_STAT); chk_addr(); chk_irq();
        serve();

        // Masked source 1 stays pending until enabled
        cfg_wr(ADDR_MASK, 32'h0);
        pulse(8'h02);
        push_exp("m1_pend", 32'h02);
        push_exp("m1_irq_masked", 32'h0);
        chk_reg(ADDR_PEND);
        tick();
        chk_irq();
        push_exp("m1_irq_at_wr", 32'h0);
        cfg_wr(ADDR_MASK, 32'h02);
        chk_irq();
        push_exp("m1_irq", 32'h1);
        push_exp("m1_addr", 32'h58);
        tick();
        chk_irq(); chk_addr();
        serve();

        // Write-1-to-clear on PEND
        cfg_wr(ADDR_MASK, 32'h0);
        pulse(8'hC0);
        push_exp("w1c_before", 32'hC0);
        chk_reg(ADDR_PEND);
        cfg_wr(ADDR_PEND, 32'h40);
        push_exp("w1c_partial", 32'h80);
        chk_reg(ADDR_PEND);
        cfg_wr(ADDR_PEND, 32'h80);
        push_exp("w1c_all", 32'h0);
        chk_reg(ADDR_PEND);

        // Frozen request while MASK/VBASE change
        cfg_wr(ADDR_MASK, 32'hFF);
        pulse(8'h10);
        tick();
        push_exp("frz_addr", 32'h70);
        push_exp("frz_stat", 32'h84);
        chk_addr(); chk_reg(ADDR_STAT);
        cfg_wr(ADDR_MASK, 32'h0);
        cfg_wr(ADDR_VBASE, 32'h1000);
        push_exp("frz_addr_after_wr", 32'h70);
        push_exp("frz_irq_after_wr", 32'h1);
        push_exp("frz_stat_after_wr", 32'h84);
        push_exp("frz_vbase_rd", 32'h1000);
        chk_addr(); chk_irq(); chk_reg(ADDR_STAT); chk_reg(ADDR_VBASE);
        iack_i = 1'b1;
        tick();
        iack_i = 1'b0;
        push_exp("frz_irq_serv", 32'h0);
        chk_irq();
        cfg_wr(ADDR_STAT, 32'h0);
        cfg_wr(ADDR_MASK, 32'hFF);
        pulse(8'h02);
        tick();
        push_exp("newbase_addr", 32'h1008);
        push_exp("newbase_irq", 32'h1);
        chk_addr(); chk_irq();
        serve();

        // Edge on source 0 coinciding with its acknowledge
        pulse(8'h01);
        tick();
        push_exp("set_wins_stat_req", 32'h80);
        push_exp("set_wins_addr", 32'h1000);
        chk_reg(ADDR_STAT); chk_addr();
        iack_i    = 1'b1;
        irq_src_i = 8'h01;
        tick();
        iack_i    = 1'b0;
        irq_src_i = 8'h00;
        push_exp("set_wins_pend", 32'h01);
        push_exp("set_wins_stat_serv", 32'h80);
        push_exp("set_wins_irq_serv", 32'h0);
        chk_reg(ADDR_PEND); chk_reg(ADDR_STAT); chk_irq();
        cfg_wr(ADDR_STAT, 32'h0);
        push_exp("set_wins_stat_eoi", 32'h0);
        chk_reg(ADDR_STAT);
        tick();
        push_exp("set_wins_rereq_irq", 32'h1);
        push_exp("set_wins_rereq_stat", 32'h80);
        chk_irq(); chk_reg(ADDR_STAT);

        // Asynchronous reset while requesting
        rst_i = 1'b1;
        #1;
        push_exp("arst_irq_now", 32'h0);
        chk_irq();
        tick();
        rst_i = 1'b0;
        tick();
        push_exp("arst_mask", 32'h0);
        push_exp("arst_pend", 32'h0);
        push_exp("arst_vbase", 32'h50);
        push_exp("arst_stat", 32'h0);
        push_exp("arst_addr", 32'h50);
        push_exp("arst_irq", 32'h0);
        chk_reg(ADDR_MASK); chk_reg(ADDR_PEND); chk_reg(ADDR_VBASE); chk_reg(ADDR_STAT);
        chk_addr(); chk_irq();

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 SHALL have parameter N_SRC, default 8: number of interrupt sources, range 1..8.
REQ-002 SHALL have parameter VEC_BASE_RST, default 32'h0000_0050: reset value of the vector base register.
REQ-003 SHALL have parameter VEC_STRIDE_LOG2, default 3: log2 of the byte spacing between vectors.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; clk and rst_i are listed first.
REQ-005 clk  in  1  system clock; every flop samples on its rising edge.
REQ-006 rst_i  in  1  asynchronous reset, active-high.
REQ-007 irq_src_i  in  N_SRC  peripheral request lines; a rising edge raises a request.
REQ-008 iack_i  in  1  one-cycle acknowledge pulse from the CPU control FSM.
REQ-009 irq_o  out  1  interrupt request to the CPU.
REQ-010 irq_addr_o  out  32  handler address to the CPU PC generator.
REQ-011 cfg_we_i  in  1  config write strobe.
REQ-012 cfg_addr_i  in  2  config register select.
REQ-013 cfg_din_i  in  32  config write data.
REQ-014 cfg_dout_o  out  32  config read data; combinational from cfg_addr_i.

Function
REQ-015 Register map SHALL be: 0 MASK[N_SRC-1:0] (1 = enabled); 1 PEND (read; write-1-to-clear); 2 VBASE[31:2]; 3 STAT = {busy, 4'b0, cur_id[2:0]} in [7:0] on read, and any write is EOI. Unused read bits SHALL be 0.
REQ-016 A 0->1 transition on irq_src_i[n] SHALL set PEND[n]; a held high level SHALL NOT set it again.
REQ-017 Candidate SHALL be the lowest n where PEND[n] & MASK[n] is 1 (index 0 highest priority).
REQ-018 FSM states SHALL be IDLE, REQ, SERV.
REQ-019 IDLE->REQ on the edge where a candidate exists; that edge latches cur_id.
REQ-020 In REQ, irq_o SHALL be 1, and cur_id and irq_addr_o SHALL stay frozen until iack_i, even if MASK or PEND changes.
REQ-021 REQ->SERV on iack_i; on the same edge PEND[cur_id] SHALL clear.
REQ-022 SERV->IDLE on a write to address 3 (EOI); EOI in IDLE or REQ SHALL be ignored.
REQ-023 irq_o SHALL be 0 in IDLE and SERV; busy SHALL be 1 in REQ and SERV.
REQ-024 irq_addr_o SHALL equal VBASE + (cur_id << VEC_STRIDE_LOG2), 32-bit, with wrap-around ignored.
REQ-025 A new edge on source n in the same cycle as the clear of PEND[n] SHALL leave PEND[n] = 1: set wins.
REQ-026 iack_i outside REQ SHALL be ignored.
REQ-027 A VBASE write while in REQ SHALL take effect only after the next IDLE->REQ latch.
REQ-028 Sources n >= N_SRC SHALL read 0 and ignore writes.

Reset
REQ-029 On rst_i: MASK=0, PEND=0, VBASE=VEC_BASE_RST, state=IDLE, cur_id=0, irq_o=0, edge-detect history=0.
REQ-030 rst_i asserted in REQ or SERV SHALL drop irq_o asynchronously; no acknowledge is owed afterwards.

Configuration
REQ-031 Macro IRQ_CTL_SYNC_EN defined: each irq_src_i bit SHALL pass a 2-flop synchronizer before edge detect; PEND reads 1 after the 3rd rising edge following the source rising, and irq_o follows one edge later.
REQ-032 Macro IRQ_CTL_SYNC_EN undefined: irq_src_i is treated as synchronous; PEND reads 1 after the 1st edge, and irq_o follows one edge later.

Structure
REQ-033 Shared package irq_pkg SHALL hold the state encoding, the register address constants and the STAT bit positions.
REQ-034 Priority encoding SHALL be the sub-module irq_prio_enc: inputs PEND & MASK; outputs valid and id.

Verification
REQ-035 Reset, write MASK=0xFF, pulse irq_src_i[3] -> irq_o=1 and irq_addr_o=0x0000_0068; iack_i -> PEND=0x00, STAT=0x83; EOI -> STAT=0x00.
REQ-036 Sources 5 and 2 raised in the same cycle with MASK=0xFF -> cur_id=2 served first; after EOI, cur_id=5 with irq_addr_o=0x0000_0078.
REQ-037 MASK=0x00 with source 1 edge -> PEND=0x02 and irq_o stays 0; write MASK=0x02 -> irq_o=1 on the next edge.
REQ-038 In REQ for id 4, write MASK=0x00 and VBASE=0x1000 -> irq_addr_o stays 0x0000_0070 until iack_i; the next request uses base 0x1000.
REQ-039 New edge on source 0 in the same cycle as iack_i for id 0 -> PEND[0] stays 1; after EOI a second request is raised for id 0.
REQ-040 rst_i asserted mid-REQ -> irq_o=0 immediately; all registers at reset values after release.
